// File: rtl/ex_mem_reg_pkg.sv
// Shared widths, control encodings and stall-mode decode for the EX/MEM pipeline register.
package ex_mem_reg_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ADDR_W  = 5;
    localparam int DEF_STALL_W = 6;

    localparam logic [DEF_DATA_W-1:0] ZERO_WORD     = '0;
    localparam logic                  WRITE_ENABLE  = 1'b1;
    localparam logic                  WRITE_DISABLE = 1'b0;
    localparam logic                  RST_ENABLE    = 1'b1;

    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;

    localparam logic [1:0] ACC_IDLE = 2'b00;
    localparam logic [1:0] ACC_ONE  = 2'b01;

    typedef enum logic [1:0] {
        MODE_ADVANCE = 2'd0,
        MODE_BUBBLE  = 2'd1,
        MODE_HOLD    = 2'd2,
        MODE_FLUSH   = 2'd3
    } ex_mem_mode_e;

    // EX running while MEM is held cannot happen on a monotonic stall vector; hold is the safe reading.
    function automatic ex_mem_mode_e decode_mode(input logic flush, input logic ex_stall,
                                                 input logic mem_stall);
        if (flush)
            return MODE_FLUSH;
        else if (!ex_stall && !mem_stall)
            return MODE_ADVANCE;
        else if (ex_stall && !mem_stall)
            return MODE_BUBBLE;
        else
            return MODE_HOLD;
    endfunction

endpackage

// File: rtl/ex_mem_hilo_acc.sv
// MADD/MSUB accumulator holding register: keeps the first-cycle partial product while EX stalls.
module ex_mem_hilo_acc
    import ex_mem_reg_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  ex_mem_mode_e          mode,
    input  logic [2*DATA_W-1:0]   ex_hilo_acc,
    input  logic [1:0]            ex_acc_cnt,
    output logic [2*DATA_W-1:0]   acc_hilo,
    output logic [1:0]            acc_cnt
);

    // Only a bubble (EX stalled, MEM free) latches; any advance or flush returns to idle.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            acc_hilo <= '0;
            acc_cnt  <= ACC_IDLE;
        end else begin
            case (mode)
                MODE_ADVANCE, MODE_FLUSH: begin
                    acc_hilo <= '0;
                    acc_cnt  <= ACC_IDLE;
                end
                MODE_BUBBLE: begin
                    acc_hilo <= ex_hilo_acc;
                    acc_cnt  <= ex_acc_cnt;
                end
                default: begin
                    acc_hilo <= acc_hilo;
                    acc_cnt  <= acc_cnt;
                end
            endcase
        end
    end

endmodule

// File: rtl/ex_mem_reg.sv
// EX->MEM pipeline register: GPR/HI/LO result bundle plus the MADD/MSUB accumulator state.
module ex_mem_reg
    import ex_mem_reg_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int STALL_W = DEF_STALL_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STALL_W-1:0]    stall,
    input  logic                  flush,
    input  logic [ADDR_W-1:0]     ex_wd,
    input  logic                  ex_wreg,
    input  logic [DATA_W-1:0]     ex_wdata,
    input  logic [DATA_W-1:0]     ex_hi,
    input  logic [DATA_W-1:0]     ex_lo,
    input  logic                  ex_whilo,
    input  logic [2*DATA_W-1:0]   ex_hilo_acc,
    input  logic [1:0]            ex_acc_cnt,
    output logic [ADDR_W-1:0]     mem_wd,
    output logic                  mem_wreg,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W-1:0]     mem_hi,
    output logic [DATA_W-1:0]     mem_lo,
    output logic                  mem_whilo,
    output logic                  mem_valid,
    output logic [2*DATA_W-1:0]   acc_hilo,
    output logic [1:0]            acc_cnt
);

    ex_mem_mode_e mode;
    logic         unused_stall_bits;

    assign mode              = decode_mode(flush, stall[STALL_EX], stall[STALL_MEM]);
    assign unused_stall_bits = ^stall;

    // EX -> MEM payload register
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            mem_wd    <= '0;
            mem_wreg  <= WRITE_DISABLE;
            mem_wdata <= '0;
            mem_hi    <= '0;
            mem_lo    <= '0;
            mem_whilo <= WRITE_DISABLE;
            mem_valid <= 1'b0;
        end else begin
            case (mode)
                MODE_ADVANCE: begin
                    mem_wd    <= ex_wd;
                    mem_wreg  <= ex_wreg;
                    mem_wdata <= ex_wdata;
                    mem_hi    <= ex_hi;
                    mem_lo    <= ex_lo;
                    mem_whilo <= ex_whilo;
                    mem_valid <= 1'b1;
                end
                MODE_BUBBLE, MODE_FLUSH: begin
                    mem_wd    <= '0;
                    mem_wreg  <= WRITE_DISABLE;
                    mem_wdata <= '0;
                    mem_hi    <= '0;
                    mem_lo    <= '0;
                    mem_whilo <= WRITE_DISABLE;
                    mem_valid <= 1'b0;
                end
                default: begin
                    mem_wd    <= mem_wd;
                    mem_wreg  <= mem_wreg;
                    mem_wdata <= mem_wdata;
                    mem_hi    <= mem_hi;
                    mem_lo    <= mem_lo;
                    mem_whilo <= mem_whilo;
                    mem_valid <= mem_valid;
                end
            endcase
        end
    end

    ex_mem_hilo_acc #(
        .DATA_W (DATA_W)
    ) u_hilo_acc (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .ex_hilo_acc (ex_hilo_acc),
        .ex_acc_cnt  (ex_acc_cnt),
        .acc_hilo    (acc_hilo),
        .acc_cnt     (acc_cnt)
    );

endmodule
